// File: rtl/uart_cmd_parser_if.sv
// Byte stream from the UART receiver into the command parser, and the decoded command results.
// iRx_Done works as a one-cycle valid with no ready: the parser accepts every strobed byte.
interface uart_cmd_parser_if;
  logic [7:0] iRx_Data;
  logic       iRx_Done;
  logic       oCmd_Valid;
  logic [2:0] oCmd_Code;
  logic [4:0] oSet_Hour;
  logic [5:0] oSet_Min;
  logic [5:0] oSet_Sec;
  logic       oErr;

  modport master (
    output iRx_Data, iRx_Done,
    input  oCmd_Valid, oCmd_Code, oSet_Hour, oSet_Min, oSet_Sec, oErr
  );

  modport slave (
    input  iRx_Data, iRx_Done,
    output oCmd_Valid, oCmd_Code, oSet_Hour, oSet_Min, oSet_Sec, oErr
  );
endinterface

// File: rtl/uart_cmd_parser.sv
// Parses "$<cmd>[HHMMSS]\n" frames from a UART byte stream into command and set-time outputs.
// A partial frame is aborted when no byte arrives for P_TIMEOUT cycles.
module uart_cmd_parser #(
  parameter int unsigned P_TIMEOUT = 100_000_000
) (
  input  logic               iClk,
  input  logic               iRst,
  uart_cmd_parser_if.slave   bus,
  output logic [1:0]         oDbg_State
);

  localparam int unsigned      TW      = $clog2(P_TIMEOUT + 1);
  localparam logic [TW-1:0]    TMO_LIM = TW'(P_TIMEOUT - 1);

  localparam logic [7:0] CH_DOLLAR = 8'h24;
  localparam logic [7:0] CH_LF     = 8'h0A;
  localparam logic [7:0] CH_CR     = 8'h0D;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CMD   = 2'd1,
    ST_DIGIT = 2'd2,
    ST_TERM  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [3:0]      digit_q [6];
  logic [3:0]      digit_d [6];
  logic [2:0]      pend_q, pend_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            valid_q, valid_d;
  logic            err_q, err_d;
  logic [2:0]      code_q, code_d;
  logic [4:0]      hour_q, hour_d;
  logic [5:0]      min_q, min_d;
  logic [5:0]      sec_q, sec_d;

  logic [6:0]      hour_v, min_v, sec_v;
  logic            time_ok;
  logic [7:0]      rx_b;

  assign rx_b    = bus.iRx_Data;
  assign hour_v  = 7'(digit_q[0]) * 7'd10 + 7'(digit_q[1]);
  assign min_v   = 7'(digit_q[2]) * 7'd10 + 7'(digit_q[3]);
  assign sec_v   = 7'(digit_q[4]) * 7'd10 + 7'(digit_q[5]);
  assign time_ok = (hour_v <= 7'd23) && (min_v <= 7'd59) && (sec_v <= 7'd59);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    digit_d = digit_q;
    pend_d  = pend_q;
    tmo_d   = tmo_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    code_d  = code_q;
    hour_d  = hour_q;
    min_d   = min_q;
    sec_d   = sec_q;

    // A byte arriving on the expiry cycle wins: it is handled below and the abort is skipped.
    if (state_q == ST_IDLE || bus.iRx_Done) begin
      tmo_d = '0;
    end else if (tmo_q == TMO_LIM) begin
      tmo_d   = '0;
      err_d   = 1'b1;
      state_d = ST_IDLE;
    end else begin
      tmo_d = tmo_q + 1'b1;
    end

    if (bus.iRx_Done) begin
      if (state_q == ST_IDLE) begin
        if (rx_b == CH_DOLLAR) begin
          state_d = ST_CMD;
          cnt_d   = '0;
        end
      end else if (rx_b == CH_DOLLAR) begin
        err_d   = 1'b1;
        state_d = ST_CMD;
        cnt_d   = '0;
      end else if (rx_b != CH_CR) begin
        case (state_q)
          ST_CMD: begin
            state_d = ST_TERM;
            case (rx_b)
              "R":     pend_d = 3'd1;
              "C":     pend_d = 3'd2;
              "M":     pend_d = 3'd3;
              "T": begin
                pend_d  = 3'd4;
                cnt_d   = '0;
                state_d = ST_DIGIT;
              end
              default: begin
                err_d   = 1'b1;
                state_d = ST_IDLE;
              end
            endcase
          end
          ST_DIGIT: begin
            if (rx_b >= 8'h30 && rx_b <= 8'h39) begin
              digit_d[cnt_q] = 4'(rx_b - 8'h30);
              cnt_d          = cnt_q + 3'd1;
              if (cnt_q == 3'd5) state_d = ST_TERM;
            end else begin
              err_d   = 1'b1;
              state_d = ST_IDLE;
            end
          end
          ST_TERM: begin
            state_d = ST_IDLE;
            if (rx_b != CH_LF) begin
              err_d = 1'b1;
            end else if (pend_q == 3'd4 && !time_ok) begin
              err_d = 1'b1;
            end else begin
              valid_d = 1'b1;
              code_d  = pend_q;
              if (pend_q == 3'd4) begin
                hour_d = 5'(hour_v);
                min_d  = 6'(min_v);
                sec_d  = 6'(sec_v);
              end
            end
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      digit_q <= '{default: 4'd0};
      pend_q  <= '0;
      tmo_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= '0;
      hour_q  <= '0;
      min_q   <= '0;
      sec_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      digit_q <= digit_d;
      pend_q  <= pend_d;
      tmo_q   <= tmo_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      code_q  <= code_d;
      hour_q  <= hour_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
    end
  end

  assign bus.oCmd_Valid = valid_q;
  assign bus.oErr       = err_q;
  assign bus.oCmd_Code  = code_q;
  assign bus.oSet_Hour  = hour_q;
  assign bus.oSet_Min   = min_q;
  assign bus.oSet_Sec   = sec_q;
  assign oDbg_State     = state_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Table-driven check of uart_cmd_parser: one record per byte with the outputs expected after it,
// plus hand-written timeout and mid-frame reset sequences.
module tb_uart_cmd_parser;

  localparam int unsigned P_TMO = 50;

  typedef struct {
    logic [7:0] data;
    logic       done;
    logic       v;
    logic       e;
    logic [2:0] code;
    logic [4:0] h;
    logic [5:0] m;
    logic [5:0] s;
  } vec_t;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;

  uart_cmd_parser_if bus ();

  uart_cmd_parser #(.P_TIMEOUT(P_TMO)) dut (
    .iClk       (clk),
    .iRst       (rst),
    .bus        (bus),
    .oDbg_State (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  vec_t       vecs[$];
  logic [2:0] c_code = 3'd0;
  logic [4:0] c_h    = 5'd0;
  logic [5:0] c_m    = 6'd0;
  logic [5:0] c_s    = 6'd0;

  task automatic check_outs(input string name, input logic v, input logic e, input logic [2:0] code,
                            input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
    logic [21:0] got, exp;
    got = {bus.oCmd_Valid, bus.oErr, bus.oCmd_Code, bus.oSet_Hour, bus.oSet_Min, bus.oSet_Sec};
    exp = {v, e, code, h, m, s};
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got valid=%b err=%b code=%0d time=%0d:%0d:%0d, expected valid=%b err=%b code=%0d time=%0d:%0d:%0d",
               name, bus.oCmd_Valid, bus.oErr, bus.oCmd_Code, bus.oSet_Hour, bus.oSet_Min, bus.oSet_Sec,
               v, e, code, h, m, s);
    end
  endtask

  task automatic check_val(input string name, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // driver: present one byte for one cycle, then sample just after the consuming edge
  task automatic apply(input string name, input vec_t vv);
    @(negedge clk);
    bus.iRx_Data = vv.data;
    bus.iRx_Done = vv.done;
    @(posedge clk);
    #1;
    check_outs(name, vv.v, vv.e, vv.code, vv.h, vv.m, vv.s);
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    bus.iRx_Done = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b, input logic done, input logic v, input logic e);
    vec_t vv;
    vv.data = b; vv.done = done; vv.v = v; vv.e = e;
    vv.code = c_code; vv.h = c_h; vv.m = c_m; vv.s = c_s;
    vecs.push_back(vv);
  endtask

  task automatic add_quiet(input string str);
    for (int i = 0; i < str.len(); i++) push(str[i], 1'b1, 1'b0, 1'b0);
  endtask

  task automatic add_ev(input logic [7:0] b, input logic v, input logic e, input logic [2:0] code,
                        input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
    c_code = code; c_h = h; c_m = m; c_s = s;
    push(b, 1'b1, v, e);
  endtask

  task automatic send_quiet(input string name, input string str);
    vec_t vv;
    for (int i = 0; i < str.len(); i++) begin
      vv.data = str[i]; vv.done = 1'b1; vv.v = 1'b0; vv.e = 1'b0;
      vv.code = c_code; vv.h = c_h; vv.m = c_m; vv.s = c_s;
      apply(name, vv);
    end
  endtask

  initial begin
    int err_early, err_late, valid_cnt;
    vec_t vv;

    bus.iRx_Data = 8'h00;
    bus.iRx_Done = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_outs("reset_hold", 0, 0, 3'd0, 5'd0, 6'd0, 6'd0);
    check_val("reset_state", int'(dbg_state), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_outs("after_reset", 0, 0, 3'd0, 5'd0, 6'd0, 6'd0);

    // Byte table; consecutive entries are strobed on consecutive cycles.
    add_quiet("$T123456"); add_ev(8'h0A, 1, 0, 3'd4, 5'd12, 6'd34, 6'd56);
    add_quiet("$T245900"); add_ev(8'h0A, 0, 1, 3'd4, 5'd12, 6'd34, 6'd56);
    add_quiet("$R\r");     add_ev(8'h0A, 1, 0, 3'd1, 5'd12, 6'd34, 6'd56);
    add_quiet("$T12");     add_ev("$",   0, 1, 3'd1, 5'd12, 6'd34, 6'd56);
    add_quiet("C");        add_ev(8'h0A, 1, 0, 3'd2, 5'd12, 6'd34, 6'd56);
    add_quiet("xyz\n\r");
    add_quiet("$");        add_ev("r",   0, 1, 3'd2, 5'd12, 6'd34, 6'd56);
    add_quiet("\n");
    add_quiet("$T1");      add_ev("a",   0, 1, 3'd2, 5'd12, 6'd34, 6'd56);
    add_quiet("$T126000"); add_ev(8'h0A, 0, 1, 3'd2, 5'd12, 6'd34, 6'd56);
    add_quiet("$T000060"); add_ev(8'h0A, 0, 1, 3'd2, 5'd12, 6'd34, 6'd56);
    add_quiet("$C");       add_ev("X",   0, 1, 3'd2, 5'd12, 6'd34, 6'd56);
    push("$", 1'b0, 1'b0, 1'b0);
    add_quiet("\n");
    add_quiet("$T0\r70809"); add_ev(8'h0A, 1, 0, 3'd4, 5'd7, 6'd8, 6'd9);
    add_quiet("$T235959"); add_ev(8'h0A, 1, 0, 3'd4, 5'd23, 6'd59, 6'd59);
    add_quiet("$C");       add_ev(8'h0A, 1, 0, 3'd2, 5'd23, 6'd59, 6'd59);

    foreach (vecs[i]) apply($sformatf("vec%0d_%02h", i, vecs[i].data), vecs[i]);

    // Timeout: a partial frame left idle aborts with a single error pulse near P_TMO cycles.
    send_quiet("tmo_prefix", "$T12");
    err_early = 0; err_late = 0; valid_cnt = 0;
    for (int j = 1; j <= 60; j++) begin
      idle_cycle();
      if (bus.oErr && j <= 45) err_early++;
      if (bus.oErr && j > 45)  err_late++;
      if (bus.oCmd_Valid)      valid_cnt++;
    end
    check_val("tmo_err_early", err_early, 0);
    check_val("tmo_err_pulses", err_late, 1);
    check_val("tmo_valid", valid_cnt, 0);
    check_val("tmo_state_idle", int'(dbg_state), 0);
    send_quiet("tmo_m_frame", "$M");
    vv.data = 8'h0A; vv.done = 1'b1; vv.v = 1'b1; vv.e = 1'b0;
    vv.code = 3'd3; vv.h = 5'd23; vv.m = 6'd59; vv.s = 6'd59;
    c_code = 3'd3;
    apply("tmo_m_lf", vv);

    // Reset mid-frame discards everything; the remaining bytes land in IDLE.
    send_quiet("rst_prefix", "$T0000");
    @(negedge clk);
    bus.iRx_Done = 1'b0;
    rst = 1'b1;
    #1;
    check_outs("rst_async", 0, 0, 3'd0, 5'd0, 6'd0, 6'd0);
    @(negedge clk);
    rst = 1'b0;
    c_code = 3'd0; c_h = 5'd0; c_m = 6'd0; c_s = 6'd0;
    send_quiet("rst_tail", "59\n");
    send_quiet("rst_garbage", "xyz");
    idle_cycle();
    check_outs("rst_final", 0, 0, 3'd0, 5'd0, 6'd0, 6'd0);
    check_val("rst_state_idle", int'(dbg_state), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
